// File: rtl/sum_accumulate_stage.sv
// sum_accumulate_stage: sums BLOCK_LEN consecutive adder results and queues each
// block total, its block id and (optionally) a saturation flag in a 2-entry
// first-word-fall-through FIFO drained by a valid/ready handshake.
// Optional feature macro: SUM_ACC_SATURATE_EN (clamp on overflow, report out_sat).
module sum_accumulate_stage #(
    parameter int ADDER_WIDTH = 92,
    parameter int ACC_WIDTH   = 128,
    parameter int BLOCK_LEN   = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [ADDER_WIDTH:0]   in_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_acc,
    output logic [CNT_WIDTH-1:0]   out_blk_id,
    output logic                   out_sat,
    output logic                   overrun
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] in_ext;
    logic                 complete;

    logic [ACC_WIDTH-1:0] fifo_acc_q [2];
    logic [CNT_WIDTH-1:0] fifo_id_q  [2];
    logic                 rd_ptr_q;
    logic                 wr_ptr_q;
    logic [1:0]           level_q;
    logic [CNT_WIDTH-1:0] blk_id_q;
    logic                 overrun_q;
    logic                 full;
    logic                 pop;
    logic                 push;

`ifdef SUM_ACC_SATURATE_EN
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 sat_q, sat_d;
    logic                 fifo_sat_q [2];
`endif

    // Accumulate step: next total of the running block, clamped when saturation is built in
    always_comb begin
        in_ext   = ACC_WIDTH'(in_sum);
        complete = in_valid && (cnt_q == CNT_WIDTH'(BLOCK_LEN - 1));
`ifdef SUM_ACC_SATURATE_EN
        sum_wide = {1'b0, acc_q} + {1'b0, in_ext};
        acc_d    = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
        sat_d    = sat_q | sum_wide[ACC_WIDTH];
`else
        acc_d    = acc_q + in_ext;
`endif
        cnt_d    = cnt_q + 1'b1;
    end

    // FIFO control: a pop on a full FIFO frees the slot for a same-cycle push
    always_comb begin
        full      = (level_q == 2'd2);
        pop       = out_valid && out_ready;
        push      = complete && (!full || pop);
    end

    // Accumulator and sample counter; both restart on block completion, even when dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
`ifdef SUM_ACC_SATURATE_EN
            sat_q <= 1'b0;
`endif
        end else if (in_valid) begin
            if (complete) begin
                acc_q <= '0;
                cnt_q <= '0;
`ifdef SUM_ACC_SATURATE_EN
                sat_q <= 1'b0;
`endif
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
`ifdef SUM_ACC_SATURATE_EN
                sat_q <= sat_d;
`endif
            end
        end
    end

    // FIFO storage, pointers, block id and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_acc_q[i] <= '0;
                fifo_id_q[i]  <= '0;
`ifdef SUM_ACC_SATURATE_EN
                fifo_sat_q[i] <= 1'b0;
`endif
            end
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            level_q   <= '0;
            blk_id_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_acc_q[wr_ptr_q] <= acc_d;
                fifo_id_q[wr_ptr_q]  <= blk_id_q;
`ifdef SUM_ACC_SATURATE_EN
                fifo_sat_q[wr_ptr_q] <= sat_d;
`endif
                wr_ptr_q <= ~wr_ptr_q;
                blk_id_q <= blk_id_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 2'd1;
                2'b01:   level_q <= level_q - 2'd1;
                default: level_q <= level_q;
            endcase
            if (complete && full && !pop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Outputs come straight from FIFO storage and state registers
    always_comb begin
        out_valid  = (level_q != 2'd0);
        out_acc    = fifo_acc_q[rd_ptr_q];
        out_blk_id = fifo_id_q[rd_ptr_q];
        overrun    = overrun_q;
`ifdef SUM_ACC_SATURATE_EN
        out_sat    = fifo_sat_q[rd_ptr_q];
`else
        out_sat    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_sum_accumulate_stage.sv
// Directed bench for sum_accumulate_stage: a vector table for BLOCK_LEN=4 plus
// hand sequences for BLOCK_LEN=1 backpressure/overrun and the 93-bit wrap/saturate case.
module tb_sum_accumulate_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // BLOCK_LEN=4 instance
    logic         rst4, vld4, rdy4;
    logic [92:0]  sum4;
    logic         ov4_valid, ov4_sat, ov4_ovr;
    logic [127:0] ov4_acc;
    logic [7:0]   ov4_id;

    sum_accumulate_stage #(.ADDER_WIDTH(92), .ACC_WIDTH(128), .BLOCK_LEN(4), .CNT_WIDTH(8)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(vld4), .in_sum(sum4),
        .out_valid(ov4_valid), .out_ready(rdy4), .out_acc(ov4_acc),
        .out_blk_id(ov4_id), .out_sat(ov4_sat), .overrun(ov4_ovr)
    );

    // BLOCK_LEN=1 instance
    logic         rst1, vld1, rdy1;
    logic [92:0]  sum1;
    logic         o1_valid, o1_sat, o1_ovr;
    logic [127:0] o1_acc;
    logic [7:0]   o1_id;

    sum_accumulate_stage #(.ADDER_WIDTH(92), .ACC_WIDTH(128), .BLOCK_LEN(1), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(vld1), .in_sum(sum1),
        .out_valid(o1_valid), .out_ready(rdy1), .out_acc(o1_acc),
        .out_blk_id(o1_id), .out_sat(o1_sat), .overrun(o1_ovr)
    );

    // 93-bit accumulator instance for wrap/saturate
    logic         rstw, vldw, rdyw;
    logic [92:0]  sumw;
    logic         ow_valid, ow_sat, ow_ovr;
    logic [92:0]  ow_acc;
    logic [7:0]   ow_id;

    sum_accumulate_stage #(.ADDER_WIDTH(92), .ACC_WIDTH(93), .BLOCK_LEN(2), .CNT_WIDTH(8)) dutw (
        .clk(clk), .rst(rstw), .in_valid(vldw), .in_sum(sumw),
        .out_valid(ow_valid), .out_ready(rdyw), .out_acc(ow_acc),
        .out_blk_id(ow_id), .out_sat(ow_sat), .overrun(ow_ovr)
    );

    typedef struct {
        logic         rst;
        logic         vld;
        logic [92:0]  sum;
        logic         rdy;
        logic         e_valid;
        logic [127:0] e_acc;
        logic [7:0]   e_id;
        logic         e_ov;
        logic         chk_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, int unsigned s, logic rd,
                                logic ev, int unsigned ea, int unsigned ei, logic eo, logic cd);
        vec_t t;
        t.rst = r; t.vld = v; t.sum = 93'(s); t.rdy = rd;
        t.e_valid = ev; t.e_acc = 128'(ea); t.e_id = 8'(ei); t.e_ov = eo; t.chk_data = cd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic v, input int unsigned s, input logic r);
        vld1 = v; sum1 = 93'(s); rdy1 = r;
        tick();
    endtask

    logic [92:0] big;
    logic [92:0] exp_w;
    logic        exp_ws;

    initial begin
        rst4 = 1'b1; vld4 = 1'b0; sum4 = '0; rdy4 = 1'b1;
        rst1 = 1'b1; vld1 = 1'b0; sum1 = '0; rdy1 = 1'b0;
        rstw = 1'b1; vldw = 1'b0; sumw = '0; rdyw = 1'b1;

        // reset
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1));
        // basic block 1,2,3,4 then pop
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4, 1, 1, 10, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        // second block -> id 1
        vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 6, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8, 1, 1, 26, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        // gapped input
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4, 1, 1, 10, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        // head stability under backpressure
        vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 0, 1, 8, 3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8, 3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8, 3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        // reset mid-block, then a fresh block restarts ids at 0
        vecs.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst4 = vecs[i].rst; vld4 = vecs[i].vld; sum4 = vecs[i].sum; rdy4 = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d out_valid", i), 128'(ov4_valid), 128'(vecs[i].e_valid));
            chk($sformatf("v%0d overrun", i), 128'(ov4_ovr), 128'(vecs[i].e_ov));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d out_acc", i), ov4_acc, vecs[i].e_acc);
                chk($sformatf("v%0d out_blk_id", i), 128'(ov4_id), 128'(vecs[i].e_id));
                chk($sformatf("v%0d out_sat", i), 128'(ov4_sat), 128'(0));
            end
        end

        // BLOCK_LEN=1: backpressure and overrun
        tick();
        rst1 = 1'b0;
        step1(0, 0, 0);
        chk("b1 idle valid", 128'(o1_valid), 128'(0));
        step1(1, 5, 0);
        chk("b1 push5 valid", 128'(o1_valid), 128'(1));
        chk("b1 push5 acc", o1_acc, 128'(5));
        step1(1, 6, 0);
        chk("b1 push6 head acc", o1_acc, 128'(5));
        chk("b1 push6 ovr", 128'(o1_ovr), 128'(0));
        step1(1, 7, 0);
        chk("b1 drop7 ovr", 128'(o1_ovr), 128'(1));
        chk("b1 drop7 head acc", o1_acc, 128'(5));
        chk("b1 drop7 head id", 128'(o1_id), 128'(0));
        step1(0, 0, 1);
        chk("b1 pop5 valid", 128'(o1_valid), 128'(1));
        chk("b1 pop5 head acc", o1_acc, 128'(6));
        chk("b1 pop5 head id", 128'(o1_id), 128'(1));
        step1(0, 0, 1);
        chk("b1 pop6 valid", 128'(o1_valid), 128'(0));
        chk("b1 sticky ovr", 128'(o1_ovr), 128'(1));

        // full FIFO with simultaneous pop, then sustained throughput
        rst1 = 1'b1;
        step1(0, 0, 0);
        chk("b1 rst ovr", 128'(o1_ovr), 128'(0));
        chk("b1 rst valid", 128'(o1_valid), 128'(0));
        rst1 = 1'b0;
        step1(1, 1, 0);
        step1(1, 2, 0);
        chk("b1 full head acc", o1_acc, 128'(1));
        step1(1, 9, 1);
        chk("b1 pushpop head acc", o1_acc, 128'(2));
        chk("b1 pushpop head id", 128'(o1_id), 128'(1));
        chk("b1 pushpop ovr", 128'(o1_ovr), 128'(0));
        step1(0, 0, 1);
        chk("b1 nine acc", o1_acc, 128'(9));
        chk("b1 nine id", 128'(o1_id), 128'(2));
        step1(0, 0, 1);
        chk("b1 drained valid", 128'(o1_valid), 128'(0));
        for (int k = 0; k < 3; k++) begin
            step1(1, 3 + k, 1);
            chk($sformatf("b1 tput%0d valid", k), 128'(o1_valid), 128'(1));
            chk($sformatf("b1 tput%0d acc", k), o1_acc, 128'(3 + k));
            chk($sformatf("b1 tput%0d id", k), 128'(o1_id), 128'(3 + k));
        end
        step1(0, 0, 1);
        chk("b1 tput drained", 128'(o1_valid), 128'(0));
        chk("b1 tput ovr", 128'(o1_ovr), 128'(0));

        // wrap vs saturate on a 93-bit accumulator
        big = '0;
        big[92] = 1'b1;
`ifdef SUM_ACC_SATURATE_EN
        exp_w  = '1;
        exp_ws = 1'b1;
`else
        exp_w  = '0;
        exp_ws = 1'b0;
`endif
        tick();
        rstw = 1'b0; vldw = 1'b1; sumw = big;
        tick();
        chk("w first valid", 128'(ow_valid), 128'(0));
        tick();
        vldw = 1'b0;
        chk("w valid", 128'(ow_valid), 128'(1));
        chk("w acc", 128'(ow_acc), 128'(exp_w));
        chk("w sat", 128'(ow_sat), 128'(exp_ws));
        chk("w id", 128'(ow_id), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
